// File: rtl/config_regs_bank.sv
// OBI-slave configuration/status register bank: read/write control, read-only status and
// sticky write-1-to-clear event registers, one transaction per cycle with a 1-cycle response.
module config_regs_bank #(
    parameter int                      NUM_REGS = 8,
    parameter logic [NUM_REGS*32-1:0]  RST_VAL  = '0,
    parameter logic [NUM_REGS-1:0]     RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]     W1C_MASK = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              addr_i,
    input  logic [31:0]              wdata_i,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    input  logic [NUM_REGS*32-1:0]   status_i,
    input  logic [NUM_REGS*32-1:0]   event_i,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic {IDLE, RESP} state_t;

    state_t               state_q;
    logic                 we_q;
    logic                 outOfRange_q;
    logic [3:0]           be_q;
    logic [IDX_W-1:0]     idx_q;
    logic [31:0]          wdata_q;
    logic [31:0]          regs_q [NUM_REGS];
    logic [31:0]          regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  wrPulse_q;
    logic [NUM_REGS-1:0]  wrPulse_d;
    logic [31:0]          laneMask;
    logic [31:0]          readVal;
    logic                 commit;

    assign gnt_o      = req_i;
    assign rvalid_o   = (state_q == RESP);
    assign err_o      = rvalid_o && outOfRange_q;
    assign laneMask   = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
    assign commit     = rvalid_o && we_q && !outOfRange_q && !RO_MASK[idx_q];
    assign wr_pulse_o = wrPulse_q;
    assign rdata_o    = (rvalid_o && !outOfRange_q) ? readVal : 32'h0;

    // Reads see the register before this cycle's commit; status slots read live input.
    always_comb begin
        readVal = 32'h0;
        if (RO_MASK[idx_q]) begin
            readVal = status_i[idx_q*32 +: 32];
        end else begin
            readVal = regs_q[idx_q];
        end
    end

    // Event sets are applied after the bus clear so a simultaneous set wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i]    = regs_q[i];
            wrPulse_d[i] = commit && (int'(idx_q) == i);
            if (RO_MASK[i]) begin
                regs_d[i] = 32'h0;
            end else if (W1C_MASK[i]) begin
                if (wrPulse_d[i]) begin
                    regs_d[i] = regs_q[i] & ~(wdata_q & laneMask);
                end
                regs_d[i] = regs_d[i] | event_i[i*32 +: 32];
            end else if (wrPulse_d[i]) begin
                regs_d[i] = (regs_q[i] & ~laneMask) | (wdata_q & laneMask);
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[i*32 +: 32] = RO_MASK[i] ? status_i[i*32 +: 32] : regs_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            idx_q        <= '0;
            wdata_q      <= 32'h0;
            outOfRange_q <= 1'b0;
            wrPulse_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RO_MASK[i] ? 32'h0 : RST_VAL[i*32 +: 32];
            end
        end else begin
            wrPulse_q <= wrPulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            if (req_i) begin
                state_q      <= RESP;
                we_q         <= we_i;
                be_q         <= be_i;
                idx_q        <= addr_i[IDX_W+1:2];
                wdata_q      <= wdata_i;
                // Upper address bits count too, so aliased addresses are rejected.
                outOfRange_q <= (addr_i[31:2] >= 30'(NUM_REGS));
            end else begin
                state_q <= IDLE;
            end
        end
    end

endmodule
